// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status flag unit: condition codes, flag bit
// positions and the hazard FSM encoding.
package status_flag_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    StIdle,
    StHold
  } haz_state_e;

endpackage

// File: rtl/status_flag_unit_cond_eval.sv
// Combinational ARM condition-field evaluator over {N,Z,C,V}.
module status_flag_unit_cond_eval
  import status_flag_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;  // NV is reserved and never executes
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural status register, ID-stage condition check, EXE->ID flag hazard
// resolution (bypass or one-cycle stall) and a saturating condition-fail counter.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter bit          FORWARD = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exe_valid_i,
  input  logic             exe_s_i,
  input  logic [3:0]       exe_flags_i,
  input  logic             freeze_i,
  input  logic             id_valid_i,
  input  logic [3:0]       id_cond_i,
  output logic             cond_pass_o,
  output logic             stall_req_o,
  output logic [3:0]       sr_o,
  output logic             c_out_o,
  output logic [CNT_W-1:0] fail_count_o
);

  logic             upd;
  logic [3:0]       sr_q, sr_d;
  logic [3:0]       eff;
  logic             decode;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign upd = exe_valid_i & exe_s_i & ~freeze_i;

  assign sr_d = upd ? exe_flags_i : sr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= 4'b0000;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o    = sr_q;
  assign c_out_o = sr_q[FLAG_C];

  // With forwarding, a flag-setting EXE instruction feeds ID in the same cycle.
  assign eff = (FORWARD && upd) ? exe_flags_i : sr_q;

  status_flag_unit_cond_eval u_cond_eval (
    .cond_i  (id_cond_i),
    .flags_i (eff),
    .pass_o  (decode)
  );

  if (FORWARD) begin : g_forward
    assign stall_req_o = 1'b0;
  end else begin : g_stall
    haz_state_e state_q, state_d;
    logic       stall;

    always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      unique case (state_q)
        StIdle: begin
          // upd already excludes freeze, so a frozen IDLE never stalls
          if (id_valid_i && (id_cond_i != COND_AL) && upd) begin
            stall   = 1'b1;
            state_d = StHold;
          end
        end
        StHold: begin
          if (!freeze_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    assign stall_req_o = stall;
  end

  assign cond_pass_o = id_valid_i & ~stall_req_o & decode;

  assign cnt_inc = id_valid_i & ~stall_req_o & ~freeze_i & ~decode;
  assign cnt_d   = (cnt_inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fail_count_o = cnt_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench: a forwarding and a stalling instance share stimulus; expected
// values are queued by the stimulus and compared by a negedge monitor.
module tb_status_flag_unit;

  localparam int CP = 0;
  localparam int ST = 1;
  localparam int SR = 2;
  localparam int CO = 3;
  localparam int FC = 4;
  localparam int NS = 5;

  localparam logic [3:0] EQ = 4'd0;
  localparam logic [3:0] NE = 4'd1;
  localparam logic [3:0] CS = 4'd2;
  localparam logic [3:0] AL = 4'd14;

  logic       clk, rst;
  logic       exe_valid, exe_s, freeze, id_valid;
  logic [3:0] exe_flags, id_cond;

  logic       cp_f, st_f, co_f, cp_s, st_s, co_s;
  logic [3:0] sr_f, sr_s, fc_f, fc_s;

  status_flag_unit #(.FORWARD(1'b1), .CNT_W(4)) u_fwd (
    .clk_i        (clk),
    .rst_i        (rst),
    .exe_valid_i  (exe_valid),
    .exe_s_i      (exe_s),
    .exe_flags_i  (exe_flags),
    .freeze_i     (freeze),
    .id_valid_i   (id_valid),
    .id_cond_i    (id_cond),
    .cond_pass_o  (cp_f),
    .stall_req_o  (st_f),
    .sr_o         (sr_f),
    .c_out_o      (co_f),
    .fail_count_o (fc_f)
  );

  status_flag_unit #(.FORWARD(1'b0), .CNT_W(4)) u_stl (
    .clk_i        (clk),
    .rst_i        (rst),
    .exe_valid_i  (exe_valid),
    .exe_s_i      (exe_s),
    .exe_flags_i  (exe_flags),
    .freeze_i     (freeze),
    .id_valid_i   (id_valid),
    .id_cond_i    (id_cond),
    .cond_pass_o  (cp_s),
    .stall_req_o  (st_s),
    .sr_o         (sr_s),
    .c_out_o      (co_s),
    .fail_count_o (fc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: wait expired before test completion");
    $finish;
  end

  string       name_q[$];
  int          sel_q[$];
  logic [15:0] exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic logic [15:0] actual(int sel);
    case (sel)
      0:       return {15'd0, cp_f};
      1:       return {15'd0, st_f};
      2:       return {12'd0, sr_f};
      3:       return {15'd0, co_f};
      4:       return {12'd0, fc_f};
      5:       return {15'd0, cp_s};
      6:       return {15'd0, st_s};
      7:       return {12'd0, sr_s};
      8:       return {15'd0, co_s};
      default: return {12'd0, fc_s};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sel_q.size() != 0) begin
      string       nm;
      int          sel;
      logic [15:0] ex, ac;
      nm  = name_q.pop_front();
      sel = sel_q.pop_front();
      ex  = exp_q.pop_front();
      ac  = actual(sel);
      n_chk++;
      if (ac === ex) n_pass++;
      else $display("FAIL %s.%s: got %0h, expected %0h", (sel < NS) ? "fwd" : "stl", nm, ac, ex);
    end
  end

  task automatic push(string nm, int sel, logic [15:0] v);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic chk_f(string nm, int sig, logic [15:0] v);
    push(nm, sig, v);
  endtask

  task automatic chk_s(string nm, int sig, logic [15:0] v);
    push(nm, sig + NS, v);
  endtask

  task automatic chk_both(string nm, int sig, logic [15:0] v);
    push(nm, sig, v);
    push(nm, sig + NS, v);
  endtask

  task automatic set_in(logic ev, logic es, logic [3:0] fl, logic iv, logic [3:0] ic);
    exe_valid = ev;
    exe_s     = es;
    exe_flags = fl;
    id_valid  = iv;
    id_cond   = ic;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pass masks (bit c = condition c) hand-derived for each flag setting.
  logic [3:0]  fl_tab[4];
  logic [15:0] mask_tab[4];
  logic [3:0]  exp_cnt;

  initial begin
    fl_tab   = '{4'b0100, 4'b1001, 4'b0010, 4'b1000};
    mask_tab = '{16'h66A9, 16'h565A, 16'h55A6, 16'h6A9A};
    rst    = 1'b1;
    freeze = 1'b0;
    set_in(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    if (sr_f !== 4'h0 || sr_s !== 4'h0 || co_f !== 1'b0 || co_s !== 1'b0 ||
        fc_f !== 4'h0 || fc_s !== 4'h0 || st_f !== 1'b0 || st_s !== 1'b0) begin
      n_chk++;
      $display("FAIL reset state: sr %0h/%0h c %0b/%0b fc %0h/%0h stall %0b/%0b",
               sr_f, sr_s, co_f, co_s, fc_f, fc_s, st_f, st_s);
    end else begin
      n_chk++;
      n_pass++;
    end
    chk_both("rst_sr", SR, 16'h0);
    chk_both("rst_c_out", CO, 16'h0);
    chk_both("rst_fail_count", FC, 16'h0);
    chk_both("rst_stall", ST, 16'h0);
    rst = 1'b0;

    set_in(1'b1, 1'b0, 4'b0110, 1'b0, 4'h0);
    tick();
    chk_both("sr_no_s_bit", SR, 16'h0);
    set_in(1'b1, 1'b1, 4'b0110, 1'b0, 4'h0);
    tick();
    chk_both("sr_update", SR, 16'h6);
    chk_both("c_out_update", CO, 16'h1);
    set_in(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
    tick();
    chk_both("sr_s_without_valid", SR, 16'h6);

    exp_cnt = 4'd0;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, fl_tab[k], 1'b0, 4'h0);
      tick();
      chk_both("sr_load", SR, {12'd0, fl_tab[k]});
      for (int c = 0; c < 16; c++) begin
        set_in(1'b0, 1'b0, 4'h0, 1'b1, 4'(c));
        chk_both("cond_pass", CP, {15'd0, mask_tab[k][c]});
        chk_both("no_stall", ST, 16'h0);
        chk_both("fail_count", FC, {12'd0, exp_cnt});
        tick();
        if (!mask_tab[k][c] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      end
    end
    set_in(1'b0, 1'b0, 4'h0, 1'b0, AL);
    chk_both("fail_count_sat", FC, 16'hF);
    chk_both("gated_no_id_valid", CP, 16'h0);
    tick();

    // Same-cycle EXE->ID hazard.
    set_in(1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
    tick();
    set_in(1'b1, 1'b1, 4'b0100, 1'b1, EQ);
    chk_f("haz_fwd_pass", CP, 16'h1);
    chk_f("haz_fwd_stall", ST, 16'h0);
    chk_s("haz_stall", ST, 16'h1);
    chk_s("haz_stall_pass", CP, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 4'h0, 1'b1, EQ);
    chk_s("hold_stall", ST, 16'h0);
    chk_both("hold_pass", CP, 16'h1);
    chk_both("hold_sr", SR, 16'h4);
    tick();
    set_in(1'b1, 1'b1, 4'b0000, 1'b1, EQ);
    chk_f("haz_fwd_fail", CP, 16'h0);
    chk_s("haz_stall2", ST, 16'h1);
    chk_s("haz_stall2_pass", CP, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 4'h0, 1'b1, EQ);
    chk_s("hold2_stall", ST, 16'h0);
    chk_both("hold2_pass", CP, 16'h0);
    chk_both("fail_count_sat2", FC, 16'hF);
    tick();
    set_in(1'b1, 1'b1, 4'hF, 1'b1, AL);
    chk_s("al_no_stall", ST, 16'h0);
    chk_both("al_pass", CP, 16'h1);
    chk_both("fail_count_sat3", FC, 16'hF);
    tick();
    set_in(1'b1, 1'b1, 4'b0010, 1'b1, CS);
    chk_both("sr_all_ones", SR, 16'hF);
    chk_f("cs_fwd_pass", CP, 16'h1);
    chk_s("cs_stall", ST, 16'h1);
    chk_s("cs_stall_pass", CP, 16'h0);
    tick();

    // Reset while the stalling instance sits in HOLD.
    set_in(1'b0, 1'b0, 4'h0, 1'b1, NE);
    rst = 1'b1;
    chk_both("midhold_rst_sr", SR, 16'h0);
    chk_both("midhold_rst_c_out", CO, 16'h0);
    chk_both("midhold_rst_stall", ST, 16'h0);
    chk_both("midhold_rst_fail_count", FC, 16'h0);
    chk_both("midhold_rst_pass", CP, 16'h1);
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 4'b0100, 1'b1, EQ);
    chk_s("post_rst_idle_stall", ST, 16'h1);
    chk_s("post_rst_idle_pass", CP, 16'h0);
    chk_f("post_rst_fwd_pass", CP, 16'h1);
    chk_both("post_rst_sr", SR, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 4'h0, 1'b1, EQ);
    chk_s("post_rst_hold_stall", ST, 16'h0);
    chk_both("post_rst_hold_pass", CP, 16'h1);
    tick();

    // Freeze: sr, counter and FSM all hold.
    set_in(1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
    tick();
    freeze = 1'b1;
    set_in(1'b1, 1'b1, 4'hF, 1'b1, EQ);
    chk_both("frz_pass", CP, 16'h0);
    chk_both("frz_stall", ST, 16'h0);
    tick();
    freeze = 1'b0;
    set_in(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    chk_both("frz_sr_held", SR, 16'h0);
    chk_both("frz_fail_count_held", FC, 16'h0);
    tick();
    set_in(1'b1, 1'b1, 4'b0100, 1'b1, EQ);
    chk_s("frz_pre_stall", ST, 16'h1);
    chk_f("frz_pre_fwd_pass", CP, 16'h1);
    tick();
    freeze = 1'b1;
    set_in(1'b1, 1'b1, 4'b0000, 1'b1, EQ);
    chk_s("frz_hold_stall", ST, 16'h0);
    chk_both("frz_hold_pass", CP, 16'h1);
    chk_both("frz_hold_sr", SR, 16'h4);
    tick();
    freeze = 1'b0;
    set_in(1'b1, 1'b1, 4'b0000, 1'b1, EQ);
    chk_s("frz_still_hold_stall", ST, 16'h0);
    chk_s("frz_still_hold_pass", CP, 16'h1);
    chk_f("frz_release_fwd_pass", CP, 16'h0);
    chk_both("frz_release_sr", SR, 16'h4);
    tick();
    set_in(1'b1, 1'b1, 4'b0100, 1'b1, EQ);
    chk_both("resume_sr", SR, 16'h0);
    chk_s("resume_stall", ST, 16'h1);
    chk_s("resume_stall_pass", CP, 16'h0);
    chk_f("resume_fwd_pass", CP, 16'h1);
    chk_f("resume_fwd_fail_count", FC, 16'h1);
    chk_s("resume_stl_fail_count", FC, 16'h0);
    tick();

    set_in(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
